// File: rtl/coproc_pkg.sv
// Shared coprocessor image-path definitions: default geometry, zoom FSM states
// and derived output frame size.
package coproc_pkg;

    localparam int DEF_IMG_WIDTH   = 160;
    localparam int DEF_IMG_HEIGHT  = 120;
    localparam int DEF_ZOOM_FACTOR = 4;
    localparam int OUT_WIDTH       = DEF_IMG_WIDTH * DEF_ZOOM_FACTOR;
    localparam int OUT_HEIGHT      = DEF_IMG_HEIGHT * DEF_ZOOM_FACTOR;

    typedef enum logic [2:0] {IDLE, FETCH, DRAIN, EMIT, FIN} zs_state_e;

    // Counter width that stays >= 1 bit even for a range of one.
    function automatic int cnt_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/zoom_scaler_if.sv
// Control, source-memory and output-stream signals of the zoom scaler.
// master = scaler side, slave = memory model / downstream / controller side.
interface zoom_scaler_if
    import coproc_pkg::*;
#(
    parameter int IMG_WIDTH   = DEF_IMG_WIDTH,
    parameter int IMG_HEIGHT  = DEF_IMG_HEIGHT,
    parameter int ZOOM_FACTOR = DEF_ZOOM_FACTOR
);
    localparam int XW  = $clog2(IMG_WIDTH);
    localparam int YW  = $clog2(IMG_HEIGHT);
    localparam int OXW = $clog2(IMG_WIDTH * ZOOM_FACTOR);
    localparam int OYW = $clog2(IMG_HEIGHT * ZOOM_FACTOR);

    logic           start, busy, done;
    logic           flow_enabled;
    logic [XW-1:0]  x_img;
    logic [YW-1:0]  y_img;
    logic           pixel_in_valid;
    logic [7:0]     pixel_in;
    logic           out_valid, out_ready, out_last;
    logic [7:0]     out_pixel;
    logic [OXW-1:0] out_x;
    logic [OYW-1:0] out_y;

    modport master (
        input  start, pixel_in_valid, pixel_in, out_ready,
        output busy, done, flow_enabled, x_img, y_img,
               out_valid, out_pixel, out_x, out_y, out_last
    );
    modport slave (
        output start, pixel_in_valid, pixel_in, out_ready,
        input  busy, done, flow_enabled, x_img, y_img,
               out_valid, out_pixel, out_x, out_y, out_last
    );
endinterface

// File: rtl/line_buffer.sv
// One-row pixel store: simple dual-port RAM, synchronous write, registered read
// with write-first forwarding on an address collision.
module line_buffer #(
    parameter int DEPTH = 160,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          wr_en,
    input  logic [AW-1:0] wr_addr,
    input  logic [7:0]    wr_data,
    input  logic          rd_en,
    input  logic [AW-1:0] rd_addr,
    output logic [7:0]    rd_data
);
    logic [7:0] mem [DEPTH];

    always_ff @(posedge clk)
        if (wr_en) mem[wr_addr] <= wr_data;

    always_ff @(posedge clk)
        if (reset)      rd_data <= '0;
        else if (rd_en) rd_data <= (wr_en && wr_addr == rd_addr) ? wr_data : mem[rd_addr];
endmodule

// File: rtl/zoom_scaler.sv
// Nearest-neighbour zoom: fetch one source row into a line buffer, then replay
// it ZOOM_FACTOR times with each pixel repeated ZOOM_FACTOR times.
module zoom_scaler
    import coproc_pkg::*;
#(
    parameter int IMG_WIDTH   = DEF_IMG_WIDTH,
    parameter int IMG_HEIGHT  = DEF_IMG_HEIGHT,
    parameter int ZOOM_FACTOR = DEF_ZOOM_FACTOR
) (
    input logic           clk,
    input logic           reset,
    zoom_scaler_if.master bus
);
    localparam int XW  = $clog2(IMG_WIDTH);
    localparam int YW  = $clog2(IMG_HEIGHT);
    localparam int OXW = $clog2(IMG_WIDTH * ZOOM_FACTOR);
    localparam int OYW = $clog2(IMG_HEIGHT * ZOOM_FACTOR);
    localparam int RW  = cnt_w(ZOOM_FACTOR);

    localparam logic [XW-1:0]  X_MAX  = XW'(IMG_WIDTH - 1);
    localparam logic [YW-1:0]  Y_MAX  = YW'(IMG_HEIGHT - 1);
    localparam logic [RW-1:0]  R_MAX  = RW'(ZOOM_FACTOR - 1);
    localparam logic [OXW-1:0] OX_MAX = OXW'(IMG_WIDTH * ZOOM_FACTOR - 1);
    localparam logic [OYW-1:0] OY_MAX = OYW'(IMG_HEIGHT * ZOOM_FACTOR - 1);

    zs_state_e     state;
    logic [XW-1:0] src_x, cap_idx, rd_addr;
    logic [RW-1:0] rep_x, rep_y;
    logic          cap_vld, hs, row_end, wr_en, rd_en;
    logic [7:0]    rd_data;

    assign hs      = bus.out_valid && bus.out_ready;
    assign row_end = (bus.out_x == OX_MAX);
    assign wr_en   = cap_vld && bus.pixel_in_valid;
    assign rd_en   = (state == DRAIN) || (state == EMIT && hs);
    assign bus.out_pixel = rd_data;

    // Read address is the column shown after the pending handshake, so the
    // registered read keeps up at one pixel per cycle.
    always_comb begin
        rd_addr = src_x;
        if (state == EMIT && rep_x == R_MAX)
            rd_addr = (src_x == X_MAX) ? '0 : src_x + 1'b1;
    end

    line_buffer #(.DEPTH(IMG_WIDTH), .AW(XW)) u_line_buffer (
        .clk     (clk),
        .reset   (reset),
        .wr_en   (wr_en),
        .wr_addr (cap_idx),
        .wr_data (bus.pixel_in),
        .rd_en   (rd_en),
        .rd_addr (rd_addr),
        .rd_data (rd_data)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state            <= IDLE;
            bus.busy         <= 1'b0;
            bus.done         <= 1'b0;
            bus.flow_enabled <= 1'b0;
            bus.out_valid    <= 1'b0;
            bus.out_last     <= 1'b0;
            bus.x_img        <= '0;
            bus.y_img        <= '0;
            bus.out_x        <= '0;
            bus.out_y        <= '0;
            src_x            <= '0;
            rep_x            <= '0;
            rep_y            <= '0;
            cap_vld          <= 1'b0;
            cap_idx          <= '0;
        end else begin
            // Memory answers one cycle after the address: remember which column.
            cap_vld  <= bus.flow_enabled;
            cap_idx  <= bus.x_img;
            bus.done <= 1'b0;
            case (state)
                IDLE: if (bus.start) begin
                    state            <= FETCH;
                    bus.busy         <= 1'b1;
                    bus.flow_enabled <= 1'b1;
                    bus.x_img        <= '0;
                    bus.y_img        <= '0;
                    bus.out_x        <= '0;
                    bus.out_y        <= '0;
                    src_x            <= '0;
                    rep_x            <= '0;
                    rep_y            <= '0;
                end
                FETCH: if (bus.x_img == X_MAX) begin
                    bus.x_img        <= '0;
                    bus.flow_enabled <= 1'b0;
                    state            <= DRAIN;
                end else begin
                    bus.x_img <= bus.x_img + 1'b1;
                end
                DRAIN: begin
                    state         <= EMIT;
                    bus.out_valid <= 1'b1;
                    bus.out_last  <= (bus.out_x == OX_MAX) && (bus.out_y == OY_MAX);
                end
                EMIT: if (hs) begin
                    if (rep_x == R_MAX) begin
                        rep_x <= '0;
                        src_x <= (src_x == X_MAX) ? '0 : src_x + 1'b1;
                    end else begin
                        rep_x <= rep_x + 1'b1;
                    end
                    if (!row_end) begin
                        bus.out_x    <= bus.out_x + 1'b1;
                        bus.out_last <= (bus.out_y == OY_MAX) && (bus.out_x + 1'b1 == OX_MAX);
                    end else begin
                        bus.out_x <= '0;
                        if (rep_y != R_MAX) begin
                            rep_y        <= rep_y + 1'b1;
                            bus.out_y    <= bus.out_y + 1'b1;
                            bus.out_last <= (OX_MAX == '0) && (bus.out_y + 1'b1 == OY_MAX);
                        end else begin
                            rep_y         <= '0;
                            bus.out_valid <= 1'b0;
                            bus.out_last  <= 1'b0;
                            if (bus.y_img == Y_MAX) begin
                                state    <= FIN;
                                bus.done <= 1'b1;
                            end else begin
                                bus.y_img        <= bus.y_img + 1'b1;
                                bus.out_y        <= bus.out_y + 1'b1;
                                bus.flow_enabled <= 1'b1;
                                state            <= FETCH;
                            end
                        end
                    end
                end
                FIN: begin
                    state    <= IDLE;
                    bus.busy <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_zoom_scaler.sv
// Bench for zoom_scaler at W=4, H=3, Z=2 with a one-cycle-latency memory model
// holding pixel = 16*y + x and a queue of expected output pixels.
module tb_zoom_scaler;
    import coproc_pkg::*;

    localparam int W = 4, H = 3, Z = 2;
    localparam int OW = W * Z, OH = H * Z, N = OW * OH;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    zoom_scaler_if #(.IMG_WIDTH(W), .IMG_HEIGHT(H), .ZOOM_FACTOR(Z)) bus ();
    zoom_scaler #(.IMG_WIDTH(W), .IMG_HEIGHT(H), .ZOOM_FACTOR(Z)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    typedef struct {
        logic [7:0] pix;
        int         x;
        int         y;
        logic       last;
    } exp_t;

    exp_t       exp_q[$];
    exp_t       e;
    int         tests = 0, fails = 0, cyc = 0;
    bit         drop = 1'b0;
    int         start_cyc, first_vld, done_cyc, done_cnt, n_out, last_x, last_y;
    logic [7:0] got [OH][OW];
    bit         pv = 1'b0, pr = 1'b0;
    int         ph = 0;

    task automatic chk(input string name, input int act, input int exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Source memory: data one cycle after the address; optional dropout at (2,1).
    always @(posedge clk) begin
        bus.pixel_in_valid <= bus.flow_enabled && !(drop && bus.x_img == 2 && bus.y_img == 1);
        bus.pixel_in       <= 8'(16 * bus.y_img + bus.x_img);
    end

    function automatic int snap();
        return {bus.out_valid, bus.out_last, bus.out_y, bus.out_x, bus.out_pixel};
    endfunction

    // Output checker: samples on the falling edge, away from the active edge.
    always @(negedge clk) begin
        cyc++;
        if (reset) begin
            pv = 1'b0;
        end else begin
            if (bus.start && !bus.busy && start_cyc < 0) start_cyc = cyc;
            if (bus.done) begin
                done_cnt++;
                if (done_cyc < 0) done_cyc = cyc;
            end
            if (pv && !pr) chk("stall_hold", snap(), ph);
            if (exp_q.size() == 0) begin
                chk("valid_without_expected", int'(bus.out_valid), 0);
            end else if (bus.out_valid) begin
                if (first_vld < 0) first_vld = cyc;
                e = exp_q[0];
                chk("pixel", int'(bus.out_pixel), int'(e.pix));
                chk("out_x", int'(bus.out_x), e.x);
                chk("out_y", int'(bus.out_y), e.y);
                chk("out_last", int'(bus.out_last), int'(e.last));
                if (bus.out_ready) begin
                    void'(exp_q.pop_front());
                    got[e.y][e.x] = bus.out_pixel;
                    n_out++;
                    if (bus.out_last) begin
                        last_x = int'(bus.out_x);
                        last_y = int'(bus.out_y);
                    end
                end
            end
            pv = bus.out_valid;
            pr = bus.out_ready;
            ph = snap();
        end
    end

    task automatic load_frame();
        exp_q.delete();
        for (int oy = 0; oy < OH; oy++)
            for (int ox = 0; ox < OW; ox++) begin
                int sx, sy;
                sx = ox / Z;
                sy = oy / Z;
                if (drop && sx == 2 && sy == 1) sy = sy - 1;
                exp_q.push_back('{8'(16 * sy + sx), ox, oy, (ox == OW - 1 && oy == OH - 1)});
            end
        start_cyc = -1; first_vld = -1; done_cyc = -1; done_cnt = 0; n_out = 0;
        last_x = -1; last_y = -1;
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_ctrl"}, {bus.busy, bus.done, bus.flow_enabled, bus.out_valid, bus.out_last}, 0);
        chk({tag, "_addr"}, {bus.x_img, bus.y_img}, 0);
        chk({tag, "_out"}, {bus.out_x, bus.out_y, bus.out_pixel}, 0);
    endtask

    task automatic pulse_start();
        @(posedge clk); #1 bus.start = 1'b1;
        @(posedge clk); #1 bus.start = 1'b0;
    endtask

    task automatic run_frame(input bit rnd, input bit busy_start);
        load_frame();
        bus.out_ready = 1'b1;
        pulse_start();
        for (int i = 0; i < 3000 && done_cyc < 0; i++) begin
            bus.out_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            bus.start     = (busy_start && (i == 30 || i == 31));
            @(posedge clk); #1;
        end
        bus.start = 1'b0;
        bus.out_ready = 1'b1;
        chk("done_within_budget", int'(done_cyc >= 0), 1);
        chk("busy_after_done", int'(bus.busy), 0);
        chk("output_count", n_out, N);
        chk("model_drained", exp_q.size(), 0);
        chk("last_pos", last_y * 16 + last_x, (OH - 1) * 16 + (OW - 1));
        if (!rnd) begin
            chk("first_valid_latency", first_vld - start_cyc, W + 2);
            chk("frame_cycles", done_cyc - start_cyc, H * (W + 1 + W * Z * Z) + 1);
        end
        repeat (3) @(posedge clk);
        #1;
        chk("done_pulses", done_cnt, 1);
        chk("idle_after_frame", int'(bus.busy), 0);
    endtask

    initial begin
        bus.start = 1'b0;
        bus.out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1 chk_reset_vals("reset");
        reset = 1'b0;

        // Plain frame, ready held high, plus hand-computed pins.
        run_frame(1'b0, 1'b0);
        chk("pin_0_0", int'(got[0][0]), 8'h00);
        chk("pin_1_0", int'(got[0][1]), 8'h00);
        chk("pin_0_1", int'(got[1][0]), 8'h00);
        chk("pin_1_1", int'(got[1][1]), 8'h00);
        chk("pin_2_0", int'(got[0][2]), 8'h01);
        chk("pin_7_5", int'(got[5][7]), 8'h23);

        // Backpressure.
        run_frame(1'b1, 1'b0);

        // Reset in the middle of row 1 emission, then a fresh frame.
        load_frame();
        pulse_start();
        for (int i = 0; i < 200 && !(bus.out_valid && bus.out_y == 3'd2); i++) begin
            @(posedge clk); #1;
        end
        chk("reached_row1", int'(bus.out_valid && bus.out_y == 3'd2), 1);
        repeat (3) @(posedge clk);
        #1 reset = 1'b1;
        @(posedge clk);
        #1 chk_reset_vals("midframe_reset");
        reset = 1'b0;
        exp_q.delete();
        repeat (4) @(posedge clk);
        #1 chk("idle_after_reset", int'(bus.busy || bus.flow_enabled), 0);
        run_frame(1'b0, 1'b0);

        // start while busy must not restart the frame.
        run_frame(1'b0, 1'b1);

        // Missing response at source (2,1): stale buffer value from row 0.
        drop = 1'b1;
        run_frame(1'b1, 1'b0);
        drop = 1'b0;
        chk("drop_4_2", int'(got[2][4]), 8'h02);
        chk("drop_5_3", int'(got[3][5]), 8'h02);
        chk("drop_6_2", int'(got[2][6]), 8'h13);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
